// File: rtl/sdram_rd_burst_ctrl.sv
// SDRAM read sequencer: arbitrates for the command bus, issues ACT/READ/PRE, crosses rows,
// yields to refresh at burst slots and captures read data after CAS latency.
module sdram_rd_burst_ctrl #(
  parameter int unsigned ROW_W     = 12,
  parameter int unsigned COL_W     = 9,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CAS_LAT   = 3,
  parameter int unsigned T_RCD     = 3,
  parameter int unsigned T_RP      = 3
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              rd_trig,
  input  logic [BANK_W-1:0] start_bank,
  input  logic [ROW_W-1:0]  start_row,
  input  logic [COL_W-1:0]  start_col,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_req,
  input  logic              rd_en,
  input  logic              ref_req,
  output logic              flag_rd_end,
  output logic [3:0]        rd_cmd,
  output logic [ROW_W-1:0]  rd_addr,
  output logic [BANK_W-1:0] bank_addr,
  input  logic [DATA_W-1:0] sdram_dq_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  output logic              rd_busy,
  output logic              rd_done
);

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdPre = 4'b0010;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StAct   = 3'd2;
  localparam logic [2:0] StRd    = 3'd3;
  localparam logic [2:0] StPre   = 3'd4;
  localparam logic [2:0] StDrain = 3'd5;

  localparam logic [1:0] CauseDone = 2'd0;
  localparam logic [1:0] CauseRef  = 2'd1;
  localparam logic [1:0] CauseRow  = 2'd2;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PIPE_W = CAS_LAT + BURST_LEN - 1;

  localparam logic [COL_W:0]   ColStep = (COL_W + 1)'(BURST_LEN);
  localparam logic [ROW_W-1:0] PreAddr = ROW_W'(1024);

  logic [2:0]        state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [BANK_W-1:0] ba_q, ba_d;
  logic              flag_q, flag_d;
  logic              done_q, done_d;
  logic [PIPE_W-1:0] pipe_q;
  logic [DATA_W-1:0] data_q;
  logic              vld_q;
  logic [COL_W:0]    col_sum;
  logic              dq_vld;

  assign col_sum = {1'b0, col_q} + ColStep;
  // pipe_q[k] set means a READ was on the bus k+1 cycles ago.
  assign dq_vld  = |pipe_q[PIPE_W-1:CAS_LAT-1];

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q + CNT_W'(1);
    cause_d = cause_q;
    wrap_d  = wrap_q;
    busy_d  = busy_q;
    cmd_d   = CmdNop;
    addr_d  = '0;
    ba_d    = '0;
    flag_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rd_trig && (rd_len != '0)) begin
          bank_d  = start_bank;
          row_d   = start_row;
          col_d   = start_col;
          rem_d   = rd_len;
          wrap_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = '0;
        if (rd_en) state_d = StAct;
      end
      StAct: begin
        if (cnt_q == '0) begin
          cmd_d  = CmdAct;
          addr_d = row_q;
          ba_d   = bank_q;
        end
        if (cnt_q == CNT_W'(T_RCD - 1)) begin
          cnt_d   = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        cnt_d = (cnt_q == CNT_W'(BURST_LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          if ((rem_q == '0) || ref_req || wrap_q) begin
            if (rem_q == '0)  cause_d = CauseDone;
            else if (ref_req) cause_d = CauseRef;
            else              cause_d = CauseRow;
            // Row advance also applies when refresh pre-empts a row crossing.
            if (wrap_q) row_d = row_q + ROW_W'(1);
            wrap_d  = 1'b0;
            cmd_d   = CmdPre;
            addr_d  = PreAddr;
            ba_d    = bank_q;
            cnt_d   = CNT_W'(1);
            state_d = StPre;
          end else begin
            cmd_d  = CmdRd;
            addr_d = ROW_W'(col_q);
            ba_d   = bank_q;
            col_d  = col_sum[COL_W-1:0];
            wrap_d = col_sum[COL_W];
            rem_d  = rem_q - LEN_W'(1);
          end
        end
      end
      StPre: begin
        if (cnt_q == CNT_W'(T_RP - 1)) begin
          cnt_d = '0;
          case (cause_q)
            CauseRow: state_d = StAct;
            CauseRef: begin
              state_d = StReq;
              flag_d  = 1'b1;
            end
            default: begin
              state_d = StDrain;
              flag_d  = 1'b1;
            end
          endcase
        end
      end
      StDrain: begin
        cnt_d = '0;
        if (pipe_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= StIdle;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      cause_q <= CauseDone;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      cmd_q   <= CmdNop;
      addr_q  <= '0;
      ba_q    <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      pipe_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      pipe_q  <= {pipe_q[PIPE_W-2:0], cmd_q == CmdRd};
      vld_q   <= dq_vld;
      if (dq_vld) data_q <= sdram_dq_in;
    end
  end

  assign rd_req      = (state_q == StReq);
  assign flag_rd_end = flag_q;
  assign rd_cmd      = cmd_q;
  assign rd_addr     = addr_q;
  assign bank_addr   = ba_q;
  assign rd_data     = data_q;
  assign rd_data_vld = vld_q;
  assign rd_busy     = busy_q;
  assign rd_done     = done_q;

endmodule

// File: tb/tb_sdram_rd_burst_ctrl.sv
// Scoreboard bench for sdram_rd_burst_ctrl: expected beats come from address arithmetic,
// a command-driven memory model supplies read data, a monitor pops and compares.
module tb_sdram_rd_burst_ctrl;
  localparam int ROW_W = 12, COL_W = 9, BANK_W = 2, DATA_W = 16, LEN_W = 16;
  localparam int BL = 4, CL = 3, T_RCD = 3, T_RP = 3;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  int passes = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [15:0] pat(input int b, input int r, input int c);
    logic [31:0] v;
    v = b * 32'h9e37 + r * 32'h00b5 + c * 32'h7 + 32'h5a5a;
    return v[15:0];
  endfunction

  // DUT A, default parameters
  logic              s_rst, rd_trig, rd_en, ref_req;
  logic [BANK_W-1:0] start_bank;
  logic [ROW_W-1:0]  start_row;
  logic [COL_W-1:0]  start_col;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_req, flag_rd_end, rd_data_vld, rd_busy, rd_done;
  logic [3:0]        rd_cmd;
  logic [ROW_W-1:0]  rd_addr;
  logic [BANK_W-1:0] bank_addr;
  logic [DATA_W-1:0] dq_a, rd_data;

  sdram_rd_burst_ctrl dut (
    .sclk(sclk), .s_rst(s_rst), .rd_trig(rd_trig), .start_bank(start_bank),
    .start_row(start_row), .start_col(start_col), .rd_len(rd_len), .rd_req(rd_req),
    .rd_en(rd_en), .ref_req(ref_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .bank_addr(bank_addr), .sdram_dq_in(dq_a), .rd_data(rd_data),
    .rd_data_vld(rd_data_vld), .rd_busy(rd_busy), .rd_done(rd_done)
  );

  // DUT B: BURST_LEN=8, CAS_LAT=2
  logic              s_rst_b, rd_trig_b, rd_en_b;
  logic [BANK_W-1:0] start_bank_b;
  logic [ROW_W-1:0]  start_row_b;
  logic [COL_W-1:0]  start_col_b;
  logic [LEN_W-1:0]  rd_len_b;
  logic              rd_req_b, flag_b, vld_b, busy_b, done_b;
  logic [3:0]        cmd_b;
  logic [ROW_W-1:0]  addr_b;
  logic [BANK_W-1:0] ba_b;
  logic [DATA_W-1:0] dq_b, data_b;

  sdram_rd_burst_ctrl #(.BURST_LEN(8), .CAS_LAT(2)) dut_b (
    .sclk(sclk), .s_rst(s_rst_b), .rd_trig(rd_trig_b), .start_bank(start_bank_b),
    .start_row(start_row_b), .start_col(start_col_b), .rd_len(rd_len_b), .rd_req(rd_req_b),
    .rd_en(rd_en_b), .ref_req(1'b0), .flag_rd_end(flag_b), .rd_cmd(cmd_b),
    .rd_addr(addr_b), .bank_addr(ba_b), .sdram_dq_in(dq_b), .rd_data(data_b),
    .rd_data_vld(vld_b), .rd_busy(busy_b), .rd_done(done_b)
  );

  // Scoreboard and monitor state for DUT A
  logic [15:0]      sb[$];
  logic [15:0]      mem_d[64];
  logic             exp_vld[64];
  logic [ROW_W-1:0] open_row;
  int  t_a = 0, last_act = 0, last_rd = 0, last_vld = 0;
  bit  first_rd = 0, req_prev = 0;
  int  flags = 0, reqs = 0, dones = 0, beats = 0, reads = 0;
  int  ref_mode = 0;
  bit  ref_fired = 0, fast_grant = 1;

  initial begin
    dq_a = '0;
    for (int i = 0; i < 64; i++) begin
      mem_d[i] = '0;
      exp_vld[i] = 1'b0;
    end
    forever begin
      @(negedge sclk);
      t_a++;
      if (s_rst) begin
        for (int i = 0; i < 64; i++) begin
          mem_d[i] = '0;
          exp_vld[i] = 1'b0;
        end
        sb.delete();
        req_prev = 0;
        dq_a = '0;
      end else begin
        dq_a = mem_d[t_a % 64];
        mem_d[t_a % 64] = '0;
        chk("vld_align", rd_data_vld, exp_vld[t_a % 64]);
        exp_vld[t_a % 64] = 1'b0;
        if (rd_data_vld) begin
          beats++;
          last_vld = t_a;
          if (sb.size() == 0) fail("extra_beat");
          else chk("rd_data", rd_data, sb.pop_front());
        end
        case (rd_cmd)
          4'b0011: begin
            open_row = rd_addr;
            last_act = t_a;
            first_rd = 1;
          end
          4'b0101: begin
            if (first_rd) chk("t_rcd", t_a - last_act, T_RCD);
            else chk("rd_gap", t_a - last_rd, BL);
            first_rd = 0;
            last_rd = t_a;
            reads++;
            chk("rd_a10", rd_addr[10], 1'b0);
            for (int j = 0; j < BL; j++) begin
              mem_d[(t_a + CL + j) % 64] =
                pat(int'(bank_addr), int'(open_row), int'(rd_addr[COL_W-1:0]) + j);
              exp_vld[(t_a + CL + 1 + j) % 64] = 1'b1;
            end
          end
          4'b0010: chk("pre_addr", rd_addr, 32'h400);
          4'b0111: chk("nop_addr", rd_addr, 0);
          default: fail("bad_cmd");
        endcase
        if (flag_rd_end) flags++;
        if (rd_done) begin
          dones++;
          chk("busy_at_done", rd_busy, 0);
          chk("done_after_vld", t_a - last_vld, 1);
        end
        if (rd_req && !req_prev) reqs++;
        req_prev = rd_req;
      end
    end
  end

  // Arbiter: grant immediately or after a random delay.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge sclk);
      rd_en = rd_req && (fast_grant || ($urandom_range(0, 2) == 0));
    end
  end

  // Refresh source: held until the sequencer releases the bus.
  initial begin
    ref_req = 1'b0;
    forever begin
      @(negedge sclk);
      if (flag_rd_end || ref_mode == 0) ref_req = 1'b0;
      else if (ref_mode == 1 && !ref_req && $urandom_range(0, 29) == 0) ref_req = 1'b1;
      else if (ref_mode == 2 && reads == 2 && !ref_fired) begin
        ref_req = 1'b1;
        ref_fired = 1;
      end
    end
  end

  task automatic push_exp(input int b, input int r, input int c, input int len);
    for (int i = 0; i < len * BL; i++) begin
      sb.push_back(pat(b, r, c));
      c++;
      if (c == (1 << COL_W)) begin
        c = 0;
        r = (r + 1) % (1 << ROW_W);
      end
    end
  endtask

  task automatic clr_cnt();
    flags = 0; reqs = 0; dones = 0; beats = 0; reads = 0;
  endtask

  task automatic trig(input int b, input int r, input int c, input int len);
    @(negedge sclk);
    rd_trig = 1'b1;
    start_bank = BANK_W'(b);
    start_row = ROW_W'(r);
    start_col = COL_W'(c);
    rd_len = LEN_W'(len);
    @(negedge sclk);
    rd_trig = 1'b0;
    start_row = ROW_W'($urandom);
    start_col = COL_W'($urandom);
  endtask

  task automatic do_xfer(input int b, input int r, input int c, input int len,
                         input int rmode, input bit mid_trig);
    bit got;
    got = 0;
    push_exp(b, r, c, len);
    clr_cnt();
    ref_fired = 0;
    ref_mode = rmode;
    trig(b, r, c, len);
    for (int n = 0; n < 4000; n++) begin
      @(negedge sclk);
      rd_trig = mid_trig && (n == 5);
      start_bank = BANK_W'($urandom);
      start_row = ROW_W'($urandom);
      start_col = COL_W'($urandom);
      rd_len = LEN_W'($urandom_range(1, 9));
      if (dones != 0) begin
        got = 1;
        break;
      end
    end
    rd_trig = 1'b0;
    ref_mode = 0;
    if (!got) fail("xfer_timeout");
    repeat (3) @(negedge sclk);
    chk("sb_empty", sb.size(), 0);
    chk("beats", beats, len * BL);
    chk("done_once", dones, 1);
    chk("flag_per_grant", flags, reqs);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd"}, rd_cmd, 4'b0111);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_bank"}, bank_addr, 0);
    chk({tag, "_req"}, rd_req, 0);
    chk({tag, "_flag"}, flag_rd_end, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_vld"}, rd_data_vld, 0);
    chk({tag, "_busy"}, rd_busy, 0);
    chk({tag, "_done"}, rd_done, 0);
  endtask

  // DUT B checks: READ spacing, vld onset, capture of the cycle-stamped bus.
  int  t_b = 0, b_last_rd = 0, b_reads = 0, b_beats = 0, b_start = -1, b_pre = -1;
  bit  b_done = 0, b_fin = 0;

  initial begin
    dq_b = '0;
    rd_en_b = 1'b0;
    forever begin
      @(negedge sclk);
      t_b++;
      rd_en_b = rd_req_b;
      if (!s_rst_b) begin
        if (cmd_b == 4'b0101) begin
          if (b_reads > 0) chk("b_rd_gap", t_b - b_last_rd, 8);
          else b_pre = t_b + 2;
          b_last_rd = t_b;
          b_reads++;
          b_start = t_b + 3;
        end
        if (t_b == b_start) chk("b_vld_start", vld_b, 1);
        if (t_b == b_pre) chk("b_vld_before", vld_b, 0);
        if (vld_b) begin
          b_beats++;
          chk("b_data", data_b, 16'(t_b - 1));
        end
        if (done_b) b_done = 1;
      end
      dq_b = 16'(t_b);
    end
  end

  initial begin
    s_rst_b = 1'b1;
    rd_trig_b = 1'b0;
    start_bank_b = '0;
    start_row_b = '0;
    start_col_b = '0;
    rd_len_b = '0;
    repeat (3) @(negedge sclk);
    s_rst_b = 1'b0;
    @(negedge sclk);
    rd_trig_b = 1'b1;
    start_row_b = ROW_W'(3);
    rd_len_b = LEN_W'(2);
    @(negedge sclk);
    rd_trig_b = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge sclk);
      if (b_done) break;
    end
    if (!b_done) fail("b_timeout");
    repeat (3) @(negedge sclk);
    chk("b_beats", b_beats, 16);
    chk("b_reads", b_reads, 2);
    b_fin = 1;
  end

  initial begin
    bit seen;
    rd_trig = 1'b0;
    start_bank = '0;
    start_row = '0;
    start_col = '0;
    rd_len = '0;
    s_rst = 1'b0;
    #1 s_rst = 1'b1;
    #2 chk_reset("rst_init");
    repeat (3) @(negedge sclk);
    s_rst = 1'b0;

    fast_grant = 1;
    do_xfer(0, 5, 0, 1, 0, 0);
    do_xfer(1, 7, 504, 4, 0, 0);
    chk("row_one_grant", reqs, 1);
    do_xfer(2, 9, 0, 8, 2, 0);
    chk("ref_two_grants", reqs, 2);
    do_xfer(3, 4095, 508, 2, 0, 0);

    clr_cnt();
    trig(1, 33, 0, 0);
    repeat (10) @(negedge sclk);
    chk("len0_no_req", reqs, 0);
    chk("len0_idle", rd_busy, 0);

    do_xfer(1, 100, 64, 6, 0, 1);

    fast_grant = 0;
    for (int k = 0; k < 8; k++) begin
      int c;
      c = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 127) * BL
                                      : (1 << COL_W) - BL * $urandom_range(1, 3);
      do_xfer($urandom_range(0, 3), $urandom_range(0, 4095), c, $urandom_range(1, 12), 1, 0);
    end

    // Abort mid-transfer with the asynchronous reset.
    fast_grant = 1;
    push_exp(0, 20, 0, 6);
    clr_cnt();
    trig(0, 20, 0, 6);
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge sclk);
      if (reads >= 2) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("reset_wait_reads");
    #2 s_rst = 1'b1;
    #1 chk_reset("rst_mid");
    repeat (3) @(negedge sclk);
    s_rst = 1'b0;
    do_xfer(2, 300, 128, 3, 0, 0);

    seen = 0;
    for (int n = 0; n < 2000; n++) begin
      if (b_fin) begin
        seen = 1;
        break;
      end
      @(negedge sclk);
    end
    if (!seen) fail("b_finish");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
